uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmitter of uart_rx_tx between NUM_REQ byte sources (e.g. SPI bridge, RX echo path).
//   Accepts one byte per grant and drives the transmitter's start/ready handshake.
//   Round-robin arbitration, frame-level sequencing, and a start-acknowledge watchdog.
//   Sits between the requester logic and the transmitter's uart_tx_start/uart_tx_ready pins.
// PARAMETERS
//   NUM_REQ         2    number of requesters (>=2)
//   DATA_W          8    byte width
//   TIMEOUT_CYCLES  16   max cycles start may stay high without uart_tx_ready falling
//   ID_W (localparam)    $clog2(NUM_REQ)
// PORTS
//   clk_int        in   1               single system clock, all logic on rising edge
//   uart_reset     in   1               asynchronous, active-high reset
//   arb_enable     in   1               1 = new grants allowed; an in-flight frame always completes
//   req_valid      in   NUM_REQ         requester i holds a byte
//   req_data       in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready      out  NUM_REQ         one-cycle accept pulse; transfer when valid&ready
//   uart_tx_ready  in   1               transmitter idle (1) / shifting (0)
//   uart_tx_start  out  1               start request to transmitter
//   uart_tx_data   out  DATA_W          latched byte, stable from grant until next grant
//   grant_id       out  ID_W            index of last granted requester
//   arb_busy       out  1               1 whenever state != IDLE
//   tx_done        out  1               one-cycle pulse when the frame completes
//   timeout_err    out  1               one-cycle pulse on watchdog expiry
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1 (requester 0 wins first); watchdog = 0.
//   States: IDLE -> LAUNCH -> DRAIN -> IDLE; LAUNCH -> IDLE on timeout.
//   IDLE: grant when arb_enable & uart_tx_ready & |req_valid.
//     - Winner = first valid index searching ptr+1, ptr+2, ... modulo NUM_REQ.
//     - Same cycle: req_ready[winner]=1 (only that bit).
//     - Next edge: latch uart_tx_data, set grant_id, enter LAUNCH.
//     - No grant while uart_tx_ready=0 (external busy) or arb_enable=0.
//   LAUNCH: uart_tx_start=1 (registered, first high the cycle after the grant).
//     - Watchdog counts cycles in LAUNCH.
//     - uart_tx_ready sampled 0 -> start=0 next cycle, enter DRAIN.
//     - Watchdog reaches TIMEOUT_CYCLES with ready still 1:
//       start=0, timeout_err pulse, ptr=grant_id, IDLE; byte dropped.
//     - Start-high duration in the timeout case is exactly TIMEOUT_CYCLES.
//   DRAIN: wait for uart_tx_ready=1, then tx_done pulse, ptr=grant_id, IDLE.
//     - Back-to-back frames: next grant is possible the cycle after return to IDLE.
//   The ptr always advances past the served requester (also on timeout), so no livelock.
//   req_valid dropping after accept has no effect; req_ready never asserts outside IDLE.
//   uart_reset mid-frame: immediate (async) return to reset values; no tx_done, no timeout_err.
//   Watchdog width: $clog2(TIMEOUT_CYCLES+1); it cleared on every LAUNCH entry.
// STRUCTURE
//   Package uart_arb_pkg: state enum {IDLE, LAUNCH, DRAIN}, default TIMEOUT constant.
//   Sub-module rr_priority_select (combinational):
//     inputs req vector, ptr; outputs any, winner index.
//   Remaining logic: one FSM, data/ID registers, watchdog counter.
// TESTING (NUM_REQ=2, TIMEOUT_CYCLES=16; bench transmitter model drops ready 2 cycles after start,
//          holds it low 100 cycles)
//   1 req0 valid 0xA9 -> req_ready[0] pulse once, uart_tx_data=0xA9, grant_id=0,
//     start high until ready low, single tx_done after 100-cycle busy.
//   2 req0=0x31 & req1=0x30 held valid -> grant order 0,1,0,1 over four frames, each byte transmitted intact.
//   3 model never drops ready -> start high exactly 16 cycles, timeout_err one pulse, no tx_done,
//     next grant goes to req1.
//   4 uart_reset asserted during DRAIN -> all outputs 0 without a clock edge, no tx_done; after release
//     req0 wins first.
//   5 arb_enable=0 with req1 valid -> no req_ready for 50 cycles; enable -> req_ready[1] in the same cycle.
//   6 uart_tx_ready held 0 at IDLE with req0 valid -> no grant; ready rises -> grant that cycle,
//     start next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Arbiter FSM states and the default start-acknowledge watchdog length.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the UART transmit arbiter.
// Handshakes: a requester byte moves when req_valid[i] & req_ready[i] on a rising clock edge;
// a frame starts when uart_tx_start is high and the transmitter answers by dropping uart_tx_ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  import uart_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic                      arb_enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_tx_ready;
  logic                      uart_tx_start;
  logic [DATA_W-1:0]         uart_tx_data;
  logic [ID_W-1:0]           grant_id;
  logic                      arb_busy;
  logic                      tx_done;
  logic                      timeout_err;
  arb_state_e                state_dbg;

  modport master (
    input  arb_enable, req_valid, req_data, uart_tx_ready,
    output req_ready, uart_tx_start, uart_tx_data, grant_id,
           arb_busy, tx_done, timeout_err, state_dbg
  );

  modport slave (
    output arb_enable, req_valid, req_data, uart_tx_ready,
    input  req_ready, uart_tx_start, uart_tx_data, grant_id,
           arb_busy, tx_done, timeout_err, state_dbg
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_select.sv
// Round-robin winner search: first set request starting just after ptr, wrapping modulo NUM_REQ.
module rr_priority_select #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  int idx;

  // Scan from the farthest candidate to the nearest so the nearest valid index wins.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources: round-robin grant,
// start/ready frame sequencing and a watchdog on the transmitter's start acknowledge.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic               clk_int,
  input  logic               uart_reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [WD_W-1:0]   wdog_inc;
  logic              start_q, start_d;
  logic              tx_done_q, tx_done_d;
  logic              timeout_q, timeout_d;

  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic              grant;
  logic [NUM_REQ-1:0] req_ready;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_sel (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .any    (any_req),
    .winner (winner)
  );

  // Reset also masks the accept pulse so every output reads 0 while reset is held.
  assign grant = (state_q == IDLE) && bus.arb_enable && bus.uart_tx_ready &&
                 any_req && !uart_reset;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    wdog_d     = wdog_q;
    start_d    = start_q;
    tx_done_d  = 1'b0;
    timeout_d  = 1'b0;
    wdog_inc   = wdog_q + WD_W'(1);

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          data_d     = bus.req_data[int'(winner)*DATA_W +: DATA_W];
          grant_id_d = winner;
          wdog_d     = '0;
          start_d    = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        // Expiry on the TIMEOUT_CYCLES-th start-high cycle gives exactly that many start cycles.
        if (!bus.uart_tx_ready) begin
          start_d = 1'b0;
          state_d = DRAIN;
        end else if (wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          wdog_d    = wdog_inc;
          ptr_d     = grant_id_q;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      DRAIN: begin
        if (bus.uart_tx_ready) begin
          tx_done_d = 1'b1;
          ptr_d     = grant_id_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      wdog_q     <= '0;
      start_q    <= 1'b0;
      tx_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      wdog_q     <= wdog_d;
      start_q    <= start_d;
      tx_done_q  <= tx_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.uart_tx_start = start_q;
  assign bus.uart_tx_data  = data_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.arb_busy      = (state_q != IDLE);
  assign bus.tx_done       = tx_done_q;
  assign bus.timeout_err   = timeout_q;
  assign bus.state_dbg     = state_q;

endmodule
